// File: rtl/instructions.svh
// instructions: FPU opcode type shared by the scheduler and its requesters
`ifndef INSTRUCTIONS_SVH
`define INSTRUCTIONS_SVH
typedef enum logic [3:0] {
  FPU_NOP  = 4'd0,
  FPU_ADD  = 4'd1,
  FPU_SUB  = 4'd2,
  FPU_MUL  = 4'd3,
  FPU_DIV  = 4'd4,
  FPU_SQRT = 4'd5,
  FPU_CMP  = 4'd6,
  FPU_CVT  = 4'd7
} FPUInstruction;
`endif

// File: rtl/fpu_scheduler.sv
// fpu_scheduler: round-robin sharing of one FPU among NUM_PORTS requesters, with a watchdog abort
`include "instructions.svh"
module fpu_scheduler #(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_valid,
  input  FPUInstruction        req_instr [NUM_PORTS],
  input  logic [63:0]          req_data0 [NUM_PORTS],
  input  logic [63:0]          req_data1 [NUM_PORTS],
  output logic [NUM_PORTS-1:0] req_ready,
  output logic [NUM_PORTS-1:0] resp_valid,
  output logic [63:0]          resp_result,
  output logic [3:0]           resp_flags,
  output logic                 resp_error,
  output logic                 busy,
  output logic                 fpu_start,
  output FPUInstruction        fpu_instr,
  output logic [63:0]          fpu_data0,
  output logic [63:0]          fpu_data1,
  input  logic [63:0]          fpu_result,
  input  logic                 fpu_wait,
  input  logic                 fpu_finish,
  input  logic                 fpu_z,
  input  logic                 fpu_n,
  input  logic                 fpu_c,
  input  logic                 fpu_o
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESPOND} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, port, win;
  logic [CW-1:0] cnt;
  logic found, nop, timeout, accept, unused_wait;
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NUM_PORTS);
  endfunction
  assign unused_wait = fpu_wait;
  // scanning downward lets the nearest valid port after ptr overwrite farther ones
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (req_valid[wrap(int'(ptr) + k)]) begin
        win = wrap(int'(ptr) + k);
        found = 1'b1;
      end
    end
  end
  assign nop     = req_instr[win] == FPU_NOP;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign accept  = state == IDLE && found;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (found ? (nop ? RESPOND : ISSUE) : IDLE)
            : state == ISSUE ? BUSY
            : state == BUSY  ? ((fpu_finish || timeout) ? RESPOND : BUSY)
            : IDLE;
  end
  assign req_ready  = accept ? NUM_PORTS'(1) << win : '0;
  assign resp_valid = state == RESPOND ? NUM_PORTS'(1) << port : '0;
  assign busy       = state != IDLE;
  assign fpu_start  = state == ISSUE;
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr         <= PW'(NUM_PORTS - 1);
      port        <= '0;
      cnt         <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
      resp_error  <= 1'b0;
      fpu_instr   <= FPU_NOP;
      fpu_data0   <= '0;
      fpu_data1   <= '0;
    end else begin
      cnt <= state == BUSY ? cnt + 1'b1 : '0;
      if (accept) begin
        ptr       <= win;
        port      <= win;
        fpu_instr <= req_instr[win];
        fpu_data0 <= req_data0[win];
        fpu_data1 <= req_data1[win];
      end
      if (accept && nop) begin
        resp_result <= '0;
        resp_flags  <= '0;
        resp_error  <= 1'b0;
      end
      // a finish in the last BUSY cycle beats the watchdog
      if (state == BUSY && (fpu_finish || timeout)) begin
        resp_result <= fpu_finish ? fpu_result : '0;
        resp_flags  <= fpu_finish ? {fpu_z, fpu_n, fpu_c, fpu_o} : 4'd0;
        resp_error  <= !fpu_finish;
      end
    end
  end
endmodule

// File: tb/tb_fpu_scheduler.sv
// tb_fpu_scheduler: randomized and directed checks of fpu_scheduler against a timeline model
`include "instructions.svh"
module tb_fpu_scheduler;
  localparam int N = 4;
  localparam int T = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  FPUInstruction req_instr [N];
  logic [63:0] req_data0 [N];
  logic [63:0] req_data1 [N];
  logic [N-1:0] req_ready, resp_valid;
  logic [63:0] resp_result;
  logic [3:0] resp_flags;
  logic resp_error, busy, fpu_start;
  FPUInstruction fpu_instr;
  logic [63:0] fpu_data0, fpu_data1;
  logic [63:0] fpu_result = '0;
  logic fpu_wait = 1'b0, fpu_finish = 1'b0;
  logic fpu_z = 1'b0, fpu_n = 1'b0, fpu_c = 1'b0, fpu_o = 1'b0;

  always #5 clock = ~clock;

  fpu_scheduler #(.NUM_PORTS(N), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_instr(req_instr), .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_error(resp_error), .busy(busy),
    .fpu_start(fpu_start), .fpu_instr(fpu_instr), .fpu_data0(fpu_data0), .fpu_data1(fpu_data1),
    .fpu_result(fpu_result), .fpu_wait(fpu_wait), .fpu_finish(fpu_finish),
    .fpu_z(fpu_z), .fpu_n(fpu_n), .fpu_c(fpu_c), .fpu_o(fpu_o)
  );

  int checks = 0, passes = 0;
  int cyc = 0;
  // model: the operation in flight is described by its accept, finish and response cycles
  int m_ptr, m_port, a_cyc, resp_cyc, fin_cyc;
  bit m_nop;
  FPUInstruction m_instr;
  logic [63:0] m_d0, m_d1, p_res, r_res;
  logic [3:0] p_flags, r_flags;
  bit p_err, r_err;
  int grants[$];
  int k_mask = -1, k_lat = 0;
  bit k_fixed = 1'b0, k_noise = 1'b1, k_res_fixed = 1'b0;
  FPUInstruction k_instr = FPU_ADD;
  logic [63:0] k_d0 = '0, k_d1 = '0, k_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      logic [1:0] idx;
      idx = 2'((p + k) % N);
      if (v[idx]) return int'(idx);
    end
    return -1;
  endfunction

  function automatic int rand_lat();
    int r;
    r = int'($urandom_range(0, 11));
    return r == 0 ? T : r == 1 ? T + 1 : r == 2 ? T + 2 : r == 3 ? 1000 : int'($urandom_range(1, 6));
  endfunction

  task automatic model_reset();
    m_ptr = N - 1; m_port = 0; a_cyc = -100; resp_cyc = -1; fin_cyc = -1; m_nop = 1'b0;
    m_instr = FPU_NOP; m_d0 = '0; m_d1 = '0;
    p_res = '0; p_flags = '0; p_err = 1'b0; r_res = '0; r_flags = '0; r_err = 1'b0;
  endtask

  task automatic step();
    bit idle, win_en;
    int w, lat;
    logic [1:0] wi;
    idle = cyc > resp_cyc;
    win_en = cyc >= a_cyc + 2 && cyc < resp_cyc;
    req_valid = k_mask >= 0 ? N'(k_mask) : N'($urandom);
    for (int i = 0; i < N; i++) begin
      req_instr[i] = k_fixed ? k_instr : FPUInstruction'(4'($urandom_range(0, 7)));
      req_data0[i] = k_fixed ? k_d0 : {$urandom, $urandom};
      req_data1[i] = k_fixed ? k_d1 : {$urandom, $urandom};
    end
    fpu_result = k_res_fixed ? k_res : {$urandom, $urandom};
    {fpu_z, fpu_n, fpu_c, fpu_o} = 4'($urandom);
    fpu_wait = win_en;
    fpu_finish = cyc == fin_cyc || (!win_en && k_noise && $urandom_range(0, 7) == 0);
    w = idle ? pick(req_valid, m_ptr) : -1;
    if (cyc == resp_cyc) begin
      r_res = p_res; r_flags = p_flags; r_err = p_err;
    end
    #4;
    if (!reset) begin
      check("req_ready", 64'(req_ready), w >= 0 ? 64'd1 << w : 64'd0);
      check("busy", 64'(busy), 64'(!idle));
      check("fpu_start", 64'(fpu_start), 64'(!idle && !m_nop && cyc == a_cyc + 1));
      check("resp_valid", 64'(resp_valid), (!idle && cyc == resp_cyc) ? 64'd1 << m_port : 64'd0);
      check("resp_result", resp_result, r_res);
      check("resp_flags", 64'(resp_flags), 64'(r_flags));
      check("resp_error", 64'(resp_error), 64'(r_err));
      check("fpu_instr", 64'(fpu_instr), 64'(m_instr));
      check("fpu_data0", fpu_data0, m_d0);
      check("fpu_data1", fpu_data1, m_d1);
    end
    @(posedge clock);
    if (reset) model_reset();
    else begin
      if (cyc == fin_cyc && win_en) begin
        p_res = fpu_result; p_flags = {fpu_z, fpu_n, fpu_c, fpu_o}; p_err = 1'b0;
      end
      if (w >= 0) begin
        wi = 2'(w);
        grants.push_back(w);
        m_ptr = w; m_port = w; a_cyc = cyc;
        m_instr = req_instr[wi]; m_d0 = req_data0[wi]; m_d1 = req_data1[wi];
        m_nop = req_instr[wi] == FPU_NOP;
        p_res = '0; p_flags = '0; p_err = 1'b0; fin_cyc = -1;
        if (m_nop) resp_cyc = cyc + 1;
        else begin
          lat = k_lat > 0 ? k_lat : rand_lat();
          fin_cyc = cyc + 1 + lat;
          p_err = lat > T;
          resp_cyc = lat > T ? cyc + T + 2 : fin_cyc + 1;
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      req_instr[i] = FPU_NOP; req_data0[i] = '0; req_data1[i] = '0;
    end
    model_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset fpu_instr", 64'(fpu_instr), 64'(FPU_NOP));
    check("reset resp_result", resp_result, 64'd0);
    k_noise = 1'b0; k_mask = 0; k_fixed = 1'b1; k_res_fixed = 1'b1;
    step();
    // single ADD from port 2, finish at cycle 5
    k_mask = 4'b0100; k_instr = FPU_ADD; k_lat = 4;
    k_d0 = 64'h3ff3333333333333; k_d1 = 64'h400b333333333333; k_res = 64'h4012666666666666;
    step();
    k_mask = 0;
    check("add fpu_start", 64'(fpu_start), 64'd1);
    check("add fpu_data0", fpu_data0, 64'h3ff3333333333333);
    repeat (5) step();
    check("add resp_valid", 64'(resp_valid), 64'b0100);
    check("add resp_result", resp_result, 64'h4012666666666666);
    check("add resp_error", 64'(resp_error), 64'd0);
    step();
    // NOP from port 1
    k_mask = 4'b0010; k_instr = FPU_NOP;
    step();
    k_mask = 0;
    check("nop resp_valid", 64'(resp_valid), 64'b0010);
    check("nop resp_result", resp_result, 64'd0);
    check("nop fpu_start", 64'(fpu_start), 64'd0);
    step();
    // timeout with a late finish at relative cycle 25
    k_mask = 4'b0001; k_instr = FPU_MUL; k_lat = 24;
    step();
    k_mask = 0;
    repeat (17) step();
    check("timeout resp_valid", 64'(resp_valid), 64'b0001);
    check("timeout resp_error", 64'(resp_error), 64'd1);
    n = 0;
    repeat (12) begin
      step();
      if (resp_valid != 0) n++;
    end
    check("timeout extra responses", 64'(n), 64'd0);
    // finish in the final BUSY cycle
    k_mask = 4'b1000; k_instr = FPU_DIV; k_lat = T; k_res = 64'hc000123456789abc;
    step();
    k_mask = 0;
    repeat (T + 1) step();
    check("tie resp_valid", 64'(resp_valid), 64'b1000);
    check("tie resp_error", 64'(resp_error), 64'd0);
    check("tie resp_result", resp_result, 64'hc000123456789abc);
    step();
    // fairness with every port valid
    reset = 1'b1;
    step();
    reset = 1'b0;
    grants.delete();
    k_mask = 4'hF; k_instr = FPU_ADD; k_lat = 3;
    for (int i = 0; i < 40 && grants.size() < 5; i++) step();
    for (int i = 0; i < 5; i++)
      check($sformatf("fair grant %0d", i), i < grants.size() ? 64'(grants[i]) : '1, 64'(i % N));
    k_mask = 0;
    repeat (T + 4) if (cyc <= resp_cyc) step();
    step();
    // reset while BUSY
    k_mask = 4'b0100; k_lat = 1000;
    step();
    k_mask = 0;
    repeat (4) step();
    check("midbusy busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("post reset busy", 64'(busy), 64'd0);
    check("post reset resp_valid", 64'(resp_valid), 64'd0);
    check("post reset fpu_start", 64'(fpu_start), 64'd0);
    check("post reset fpu_instr", 64'(fpu_instr), 64'(FPU_NOP));
    check("post reset fpu_data0", fpu_data0, 64'd0);
    check("post reset resp_result", resp_result, 64'd0);
    grants.delete();
    k_mask = 4'hF; k_lat = 2;
    step();
    check("post reset grant", grants.size() > 0 ? 64'(grants[0]) : '1, 64'd0);
    // randomized traffic
    k_mask = -1; k_fixed = 1'b0; k_lat = 0; k_res_fixed = 1'b0; k_noise = 1'b1;
    repeat (800) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fpu_scheduler.md
# fpu_scheduler

Round-robin scheduler that shares the single FPU between `NUM_PORTS` requesters, typically the VLIW issue lanes. It accepts one request at a time, registers its operands and drives the FPU's start/instruction/operand inputs. It then waits for the FPU's finish pulse and returns the result and flags to the requester that issued the operation. A watchdog aborts operations whose finish pulse never arrives.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 2048: maximum BUSY cycles before abort, power of two ≥ 16.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_PORTS  per-port request valid.
- `req_instr`  in  NUM_PORTS × FPUInstruction  per-port opcode, type from rtl/instructions.svh.
- `req_data0`, `req_data1`  in  NUM_PORTS × 64  per-port operands.
- `req_ready`  out  NUM_PORTS  one-hot grant, combinational.
- `resp_valid`  out  NUM_PORTS  one-hot completion pulse, registered.
- `resp_result`  out  64  result, shared by all ports.
- `resp_flags`  out  4  {z,n,c,o}.
- `resp_error`  out  1  high with `resp_valid` on timeout.
- `busy`  out  1  high whenever state ≠ IDLE.
- `fpu_start`  out  1  one-cycle start pulse to FPU.
- `fpu_instr`  out  FPUInstruction  held for the whole operation.
- `fpu_data0`, `fpu_data1`  out  64  held for the whole operation.
- `fpu_result`  in  64  FPU result.
- `fpu_wait`  in  1  FPU busy; monitored only.
- `fpu_finish`  in  1  FPU completion pulse.
- `fpu_z`, `fpu_n`, `fpu_c`, `fpu_o`  in  1 each  FPU flags.

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESPOND.
- **Reset** (synchronous, effective at any state, including mid-operation):
  - State returns to IDLE; round-robin pointer returns to `NUM_PORTS-1`, so port 0 has first priority.
  - `fpu_start`, `resp_valid`, `resp_error` and `busy` are 0; `resp_result`, `resp_flags`, `fpu_data0`/`fpu_data1` are 0; `fpu_instr` is FPU_NOP.
  - An in-flight operation is dropped with no response.
- **IDLE:**
  - `req_ready` is asserted only for the winner: the first valid port scanning upward from pointer+1, wrapping modulo NUM_PORTS.
  - No valid request: `req_ready` = 0.
  - On accept (`req_valid[i] & req_ready[i]`), register the opcode, operands and port index i, and set pointer = i.
  - Next state is ISSUE, or RESPOND if the opcode is FPU_NOP. A NOP is never sent to the FPU; it completes with result 0, flags 0, error 0.
- **ISSUE** (exactly 1 cycle):
  - `fpu_start` = 1; timeout counter cleared; go to BUSY.
  - `fpu_finish` is ignored in this cycle.
- **BUSY:**
  - Counter increments each cycle.
  - On `fpu_finish`: capture `fpu_result` and the flags, go to RESPOND.
  - Counter reaches TIMEOUT_CYCLES-1 without finish: result 0, flags 0, error 1, go to RESPOND.
  - If finish and timeout occur in the same cycle, finish wins.
- **RESPOND** (exactly 1 cycle):
  - `resp_valid[port]` = 1; result, flags and error are valid. The requester must consume in this cycle; there is no backpressure.
  - Go to IDLE.
- `req_ready` = 0 in all states except IDLE. `fpu_finish` arriving in IDLE or RESPOND (for example after a timeout) is ignored.
- `resp_result`, `resp_flags` and `resp_error` keep their last values outside RESPOND.

## Timing
- Accept at cycle 0 → `fpu_start` at cycle 1 → finish at cycle F ≥ 2 → `resp_valid` at F+1 → next accept possible at F+2.
- NOP: accept at 0, `resp_valid` at 1, next accept at 2.
- Timeout: `resp_valid` with error at cycle 1 + TIMEOUT_CYCLES + 1.
- `fpu_instr`, `fpu_data0` and `fpu_data1` are stable from cycle 1 until the next accept.
- Fairness: with all ports continuously valid, grants follow 0,1,…,NUM_PORTS-1,0,…

## Test plan
- **Single ADD:** port 2 requests FPU_ADD with 0x3ff3333333333333 and 0x400b333333333333; the FPU model returns 0x4012666666666666 at cycle 5 → `resp_valid` = 0b0100 at cycle 6, `resp_result` = 0x4012666666666666, `resp_error` = 0.
- **Round-robin:** all 4 ports valid continuously, each op finishing 3 cycles after start → grant order 0,1,2,3,0; `req_ready` one-hot and only in IDLE.
- **NOP shortcut:** port 1 sends FPU_NOP → `fpu_start` never asserted, `resp_valid[1]` at cycle 1, result 0.
- **Timeout:** TIMEOUT_CYCLES = 16, FPU never finishes → `resp_error` = 1 with `resp_valid` at cycle 18; a late `fpu_finish` at cycle 25 is ignored and no second response occurs.
- **Reset mid-BUSY:** assert `reset` during BUSY → next cycle state is IDLE, all outputs at reset values, no `resp_valid`, and the next grant goes to port 0.
- **Finish/timeout tie:** `fpu_finish` in the final BUSY cycle → the FPU result is returned with `resp_error` = 0.
